mpu_load_store_ctrl: RTL and testbench
======================================

MPU_LOAD_STORE_CTRL -- requirements
Module: mpu_load_store_ctrl

Interface
REQ-001 SHALL use clk (input, 1): rising-edge clock for all state.
REQ-002 SHALL use rst (input, 1): reset, asynchronous, active-low.
REQ-003 SHALL take parameters M, N, MBITS, NBITS and MATRIX_REG_BITS from global_defs, and float_sp (32-bit) from mpu_data_types.
REQ-004 SHALL provide these ports:
- load_req  in  1  memory-side load request
- store_req  in  1  memory-side store request
- mem_load_element  in  float_sp  incoming element
- mem_m_load_size  in  MBITS+1  load rows
- mem_n_load_size  in  NBITS+1  load columns
- mem_load_addr  in  MATRIX_REG_BITS+1  destination register
- mem_store_addr  in  MATRIX_REG_BITS+1  source register
- mem_load_ack  out  1  element-accept window
- mem_load_error  out  1  one-cycle size-error pulse
- mem_store_en  out  1  store element valid
- mem_store_element  out  float_sp  outgoing element
- mem_m_store_size  out  MBITS+1  stored rows
- mem_n_store_size  out  NBITS+1  stored columns
- load_ready  out  1  idle, load accepted next cycle
- store_ready  out  1  idle, store accepted next cycle
- reg_load_en  out  1  register-file write strobe
- reg_load_addr  out  MATRIX_REG_BITS+1  write register
- reg_load_element  out  float_sp  write data
- reg_m_load_size  out  MBITS+1  written rows
- reg_n_load_size  out  NBITS+1  written columns
- reg_i_load_loc  out  MBITS+1  write row
- reg_j_load_loc  out  NBITS+1  write column
- reg_store_en  out  1  register-file read strobe
- reg_store_addr  out  MATRIX_REG_BITS+1  read register
- reg_i_store_loc  out  MBITS+1  read row
- reg_j_store_loc  out  NBITS+1  read column
- reg_store_element  in  float_sp  read data, valid one cycle after reg_store_en
- reg_m_store_size  in  MBITS+1  stored rows of reg_store_addr, combinational
- reg_n_store_size  in  NBITS+1  stored columns of reg_store_addr, combinational

Function
REQ-005 SHALL implement FSM states IDLE, LOAD, LOAD_DONE, STORE, STORE_DONE; load_ready and store_ready are high only in IDLE.
REQ-006 In IDLE, load_req SHALL win over a simultaneous store_req.
REQ-007 In IDLE with load_req high, sizes and address SHALL be latched; m=0, n=0, m>M or n>N SHALL pulse mem_load_error for 1 cycle and go to LOAD_DONE; otherwise go to LOAD.
REQ-008 mem_load_ack SHALL be high for exactly m*n consecutive cycles starting the cycle after acceptance; element k is sampled on the k-th ack-high edge.
REQ-009 Each sampled element SHALL produce reg_load_en the next cycle with latched addr/sizes, i=k/n, j=k%n; order is row-major, j wraps to 0 with i+1.
REQ-010 After the last element, SHALL enter LOAD_DONE and return to IDLE once load_req is low.
REQ-011 In IDLE with store_req high (no load_req), the FSM SHALL enter STORE, drive reg_store_addr=mem_store_addr and latch reg_m/n_store_size.
REQ-012 Stored size 0 or out of range SHALL pulse mem_load_error and go to STORE_DONE without asserting mem_store_en.
REQ-013 STORE SHALL assert reg_store_en for m*n cycles, stepping i/j row-major.
REQ-014 mem_store_en SHALL be high with mem_store_element=reg_store_element exactly one cycle after each reg_store_en cycle, giving 2-cycle latency and m*n contiguous cycles; mem_m/n_store_size hold the latched sizes.
REQ-015 STORE_DONE SHALL return to IDLE when store_req is low; requests arriving outside IDLE are ignored.
REQ-016 Index counters SHALL saturate-check against the latched m/n, never against M/N.

Reset
REQ-017 rst low SHALL asynchronously force IDLE, abort any transfer and zero every output and counter, except load_ready=store_ready=1.
REQ-018 After rst deasserts, the block SHALL accept a request on the first clock edge.

Structure
REQ-019 The FSM state enum SHALL live in mpu_data_types; size limits SHALL come from global_defs only.
REQ-020 A sub-module mpu_ij_counter (row-major i/j stepper with latched bounds and last flag) SHALL be shared by the load and store paths.

Verification
REQ-021 Load 2x3, elements 1.0..6.0, addr 1 -> 6 ack cycles; reg writes (0,0)=1.0 .. (1,2)=6.0.
REQ-022 Store addr 1 after REQ-021 -> mem_store_en 6 cycles, 2 cycles after acceptance; elements 1.0..6.0; size 2x3.
REQ-023 Load with m=0 -> 1-cycle mem_load_error; no ack, no reg_load_en.
REQ-024 load_req and store_req together in IDLE -> load executes; store is served only after reissue.
REQ-025 rst low at element 3 of a 4x4 load -> outputs zero immediately; next load completes normally.
REQ-026 Load MxN at maximum -> M*N acks; last write at (M-1,N-1); no counter wrap errors.

Source files
------------

// File: rtl/global_defs.sv
// Global matrix-unit dimensions shared by every MPU block.
package global_defs;

  localparam int M               = 4;
  localparam int N               = 4;
  localparam int MBITS           = 2;
  localparam int NBITS           = 2;
  localparam int MATRIX_REG_BITS = 2;

endpackage

// File: rtl/mpu_data_types.sv
// Data types shared by MPU blocks: element format and load/store FSM states.
package mpu_data_types;

  typedef logic [31:0] float_sp;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    LOAD_DONE  = 3'd2,
    STORE      = 3'd3,
    STORE_DONE = 3'd4
  } ls_state_e;

endpackage

// File: rtl/mpu_ij_counter.sv
// Row-major (i, j) stepper. Bounds are captured on start; last_o flags the
// final element (m-1, n-1), and stepping on the last element holds position.
module mpu_ij_counter
  import global_defs::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic [MBITS:0]   m_i,
  input  logic [NBITS:0]   n_i,
  output logic [MBITS:0]   i_o,
  output logic [NBITS:0]   j_o,
  output logic             last_o
);

  localparam logic [MBITS:0] I_ONE = (MBITS+1)'(1);
  localparam logic [NBITS:0] J_ONE = (NBITS+1)'(1);

  logic [MBITS:0] m_q, m_d, i_q, i_d;
  logic [NBITS:0] n_q, n_d, j_q, j_d;

  assign last_o = (i_q == m_q - I_ONE) && (j_q == n_q - J_ONE);
  assign i_o    = i_q;
  assign j_o    = j_q;

  always_comb begin
    m_d = m_q;
    n_d = n_q;
    i_d = i_q;
    j_d = j_q;
    if (start) begin
      m_d = m_i;
      n_d = n_i;
      i_d = '0;
      j_d = '0;
    end else if (step && !last_o) begin
      // j wraps against the latched column count, carrying into i
      if (j_q == n_q - J_ONE) begin
        j_d = '0;
        i_d = i_q + I_ONE;
      end else begin
        j_d = j_q + J_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q <= '0;
      n_q <= '0;
      i_q <= '0;
      j_q <= '0;
    end else begin
      m_q <= m_d;
      n_q <= n_d;
      i_q <= i_d;
      j_q <= j_d;
    end
  end

endmodule

// File: rtl/mpu_load_store_ctrl.sv
// Moves matrices between the memory side and the matrix register file,
// one element per cycle in row-major order, using a shared i/j stepper.
module mpu_load_store_ctrl
  import global_defs::*;
  import mpu_data_types::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_req,
  input  logic                       store_req,
  input  float_sp                    mem_load_element,
  input  logic [MBITS:0]             mem_m_load_size,
  input  logic [NBITS:0]             mem_n_load_size,
  input  logic [MATRIX_REG_BITS:0]   mem_load_addr,
  input  logic [MATRIX_REG_BITS:0]   mem_store_addr,
  output logic                       mem_load_ack,
  output logic                       mem_load_error,
  output logic                       mem_store_en,
  output float_sp                    mem_store_element,
  output logic [MBITS:0]             mem_m_store_size,
  output logic [NBITS:0]             mem_n_store_size,
  output logic                       load_ready,
  output logic                       store_ready,
  output logic                       reg_load_en,
  output logic [MATRIX_REG_BITS:0]   reg_load_addr,
  output float_sp                    reg_load_element,
  output logic [MBITS:0]             reg_m_load_size,
  output logic [NBITS:0]             reg_n_load_size,
  output logic [MBITS:0]             reg_i_load_loc,
  output logic [NBITS:0]             reg_j_load_loc,
  output logic                       reg_store_en,
  output logic [MATRIX_REG_BITS:0]   reg_store_addr,
  output logic [MBITS:0]             reg_i_store_loc,
  output logic [NBITS:0]             reg_j_store_loc,
  input  float_sp                    reg_store_element,
  input  logic [MBITS:0]             reg_m_store_size,
  input  logic [NBITS:0]             reg_n_store_size,
  output ls_state_e                  dbg_state
);

  // Handshake: a request is taken on the edge where it is high and the
  // matching *_ready is high; requests seen in any other state are dropped.

  localparam logic [MBITS:0] M_LIM = (MBITS+1)'(M);
  localparam logic [NBITS:0] N_LIM = (NBITS+1)'(N);

  function automatic logic size_ok(input logic [MBITS:0] m, input logic [NBITS:0] n);
    return (m != '0) && (n != '0) && (m <= M_LIM) && (n <= N_LIM);
  endfunction

  ls_state_e                 state_q, state_d;
  logic                      ack_q, ack_d;
  logic                      err_q, err_d;
  logic                      ld_ready_q, ld_ready_d;
  logic                      st_ready_q, st_ready_d;
  logic                      mst_en_q, mst_en_d;
  logic                      rld_en_q, rld_en_d;
  logic                      rst_en_q, rst_en_d;
  logic [MATRIX_REG_BITS:0]  ld_addr_q, ld_addr_d;
  logic [MATRIX_REG_BITS:0]  st_addr_q, st_addr_d;
  logic [MBITS:0]            ld_m_q, ld_m_d, st_m_q, st_m_d;
  logic [NBITS:0]            ld_n_q, ld_n_d, st_n_q, st_n_d;
  logic [MBITS:0]            ld_i_q, ld_i_d;
  logic [NBITS:0]            ld_j_q, ld_j_d;
  float_sp                   ld_elem_q, ld_elem_d;

  logic                      cnt_start, cnt_step, cnt_last;
  logic [MBITS:0]            cnt_m, cnt_i;
  logic [NBITS:0]            cnt_n, cnt_j;
  logic                      store_take;

  mpu_ij_counter u_ij (
    .clk    (clk),
    .rst    (rst),
    .start  (cnt_start),
    .step   (cnt_step),
    .m_i    (cnt_m),
    .n_i    (cnt_n),
    .i_o    (cnt_i),
    .j_o    (cnt_j),
    .last_o (cnt_last)
  );

  // The register file reports sizes combinationally for reg_store_addr, so
  // the requested address is presented in the same cycle the store is taken.
  assign store_take = rst && (state_q == IDLE) && store_req && !load_req;

  always_comb begin
    state_d   = state_q;
    ack_d     = ack_q;
    err_d     = 1'b0;
    mst_en_d  = rst_en_q;
    rld_en_d  = 1'b0;
    rst_en_d  = rst_en_q;
    ld_addr_d = ld_addr_q;
    st_addr_d = st_addr_q;
    ld_m_d    = ld_m_q;
    ld_n_d    = ld_n_q;
    st_m_d    = st_m_q;
    st_n_d    = st_n_q;
    ld_i_d    = ld_i_q;
    ld_j_d    = ld_j_q;
    ld_elem_d = ld_elem_q;
    cnt_start = 1'b0;
    cnt_step  = 1'b0;
    cnt_m     = mem_m_load_size;
    cnt_n     = mem_n_load_size;
    case (state_q)
      IDLE: begin
        if (load_req) begin
          ld_addr_d = mem_load_addr;
          ld_m_d    = mem_m_load_size;
          ld_n_d    = mem_n_load_size;
          cnt_start = 1'b1;
          if (size_ok(mem_m_load_size, mem_n_load_size)) begin
            state_d = LOAD;
            ack_d   = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = LOAD_DONE;
          end
        end else if (store_req) begin
          st_addr_d = mem_store_addr;
          st_m_d    = reg_m_store_size;
          st_n_d    = reg_n_store_size;
          cnt_m     = reg_m_store_size;
          cnt_n     = reg_n_store_size;
          cnt_start = 1'b1;
          if (size_ok(reg_m_store_size, reg_n_store_size)) begin
            state_d  = STORE;
            rst_en_d = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = STORE_DONE;
          end
        end
      end
      LOAD: begin
        // ack is high for the whole of LOAD, so every edge samples one element
        rld_en_d  = 1'b1;
        ld_elem_d = mem_load_element;
        ld_i_d    = cnt_i;
        ld_j_d    = cnt_j;
        cnt_step  = 1'b1;
        if (cnt_last) begin
          ack_d   = 1'b0;
          state_d = LOAD_DONE;
        end
      end
      LOAD_DONE: begin
        if (!load_req) state_d = IDLE;
      end
      STORE: begin
        cnt_step = 1'b1;
        if (cnt_last) begin
          rst_en_d = 1'b0;
          state_d  = STORE_DONE;
        end
      end
      STORE_DONE: begin
        if (!store_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ld_ready_d = (state_d == IDLE);
    st_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      ld_ready_q <= 1'b1;
      st_ready_q <= 1'b1;
      mst_en_q   <= 1'b0;
      rld_en_q   <= 1'b0;
      rst_en_q   <= 1'b0;
      ld_addr_q  <= '0;
      st_addr_q  <= '0;
      ld_m_q     <= '0;
      ld_n_q     <= '0;
      st_m_q     <= '0;
      st_n_q     <= '0;
      ld_i_q     <= '0;
      ld_j_q     <= '0;
      ld_elem_q  <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      ld_ready_q <= ld_ready_d;
      st_ready_q <= st_ready_d;
      mst_en_q   <= mst_en_d;
      rld_en_q   <= rld_en_d;
      rst_en_q   <= rst_en_d;
      ld_addr_q  <= ld_addr_d;
      st_addr_q  <= st_addr_d;
      ld_m_q     <= ld_m_d;
      ld_n_q     <= ld_n_d;
      st_m_q     <= st_m_d;
      st_n_q     <= st_n_d;
      ld_i_q     <= ld_i_d;
      ld_j_q     <= ld_j_d;
      ld_elem_q  <= ld_elem_d;
    end
  end

  assign dbg_state         = state_q;
  assign mem_load_ack      = ack_q;
  assign mem_load_error    = err_q;
  assign load_ready        = ld_ready_q;
  assign store_ready       = st_ready_q;
  assign reg_load_en       = rld_en_q;
  assign reg_load_addr     = ld_addr_q;
  assign reg_load_element  = ld_elem_q;
  assign reg_m_load_size   = ld_m_q;
  assign reg_n_load_size   = ld_n_q;
  assign reg_i_load_loc    = ld_i_q;
  assign reg_j_load_loc    = ld_j_q;
  assign reg_store_en      = rst_en_q;
  assign reg_store_addr    = store_take ? mem_store_addr : st_addr_q;
  assign reg_i_store_loc   = rst_en_q ? cnt_i : '0;
  assign reg_j_store_loc   = rst_en_q ? cnt_j : '0;
  // Read data arrives one cycle after reg_store_en and is forwarded as-is.
  assign mem_store_en      = mst_en_q;
  assign mem_store_element = mst_en_q ? reg_store_element : '0;
  assign mem_m_store_size  = st_m_q;
  assign mem_n_store_size  = st_n_q;

endmodule

// File: tb/tb_mpu_load_store_ctrl.sv
// Bench for mpu_load_store_ctrl: a behavioural register file around the DUT,
// a matrix-level reference model, and directed plus random load/store steps.
module tb_mpu_load_store_ctrl;
  import global_defs::*;
  import mpu_data_types::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load_req = 1'b0, store_req = 1'b0;
  float_sp mem_load_element = '0;
  logic [2:0] mem_m_load_size = '0, mem_n_load_size = '0;
  logic [2:0] mem_load_addr = '0, mem_store_addr = '0;
  logic mem_load_ack, mem_load_error, mem_store_en, load_ready, store_ready;
  float_sp mem_store_element, reg_load_element, reg_store_element;
  logic [2:0] mem_m_store_size, mem_n_store_size;
  logic reg_load_en, reg_store_en;
  logic [2:0] reg_load_addr, reg_m_load_size, reg_n_load_size, reg_i_load_loc, reg_j_load_loc;
  logic [2:0] reg_store_addr, reg_i_store_loc, reg_j_store_loc;
  logic [2:0] reg_m_store_size, reg_n_store_size;
  ls_state_e dbg_state;

  mpu_load_store_ctrl dut (
    .clk(clk), .rst(rst), .load_req(load_req), .store_req(store_req),
    .mem_load_element(mem_load_element), .mem_m_load_size(mem_m_load_size),
    .mem_n_load_size(mem_n_load_size), .mem_load_addr(mem_load_addr),
    .mem_store_addr(mem_store_addr), .mem_load_ack(mem_load_ack),
    .mem_load_error(mem_load_error), .mem_store_en(mem_store_en),
    .mem_store_element(mem_store_element), .mem_m_store_size(mem_m_store_size),
    .mem_n_store_size(mem_n_store_size), .load_ready(load_ready),
    .store_ready(store_ready), .reg_load_en(reg_load_en),
    .reg_load_addr(reg_load_addr), .reg_load_element(reg_load_element),
    .reg_m_load_size(reg_m_load_size), .reg_n_load_size(reg_n_load_size),
    .reg_i_load_loc(reg_i_load_loc), .reg_j_load_loc(reg_j_load_loc),
    .reg_store_en(reg_store_en), .reg_store_addr(reg_store_addr),
    .reg_i_store_loc(reg_i_store_loc), .reg_j_store_loc(reg_j_store_loc),
    .reg_store_element(reg_store_element), .reg_m_store_size(reg_m_store_size),
    .reg_n_store_size(reg_n_store_size), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural register file ----------------
  logic [31:0] rf_data [8][8][8];
  logic [2:0]  rf_m [8];
  logic [2:0]  rf_n [8];
  initial begin
    for (int a = 0; a < 8; a++) begin
      rf_m[a] = '0;
      rf_n[a] = '0;
    end
  end
  assign reg_m_store_size = rf_m[reg_store_addr];
  assign reg_n_store_size = rf_n[reg_store_addr];
  always @(posedge clk) begin
    reg_store_element <= reg_store_en ? rf_data[reg_store_addr][reg_i_store_loc][reg_j_store_loc] : 32'h0;
    if (reg_load_en) begin
      rf_data[reg_load_addr][reg_i_load_loc][reg_j_load_loc] = reg_load_element;
      rf_m[reg_load_addr] = reg_m_load_size;
      rf_n[reg_load_addr] = reg_n_load_size;
    end
  end

  // ---------------- reference model and scoreboard ----------------
  logic [31:0] mdl_data [8][8][8];
  int          mdl_m [8];
  int          mdl_n [8];
  logic [31:0] ld_data [16];
  logic [46:0] exp_ld[$], got_ld[$];
  logic [37:0] exp_st[$], got_st[$];
  int ack_cnt, ack_first, err_cnt, st_first, st_last, acc_cyc, cur_mn;
  bit cur_valid;
  int checks = 0, errors = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (mem_load_ack) begin
        if (ack_first < 0) ack_first = cyc;
        ack_cnt++;
      end
      if (mem_load_error) err_cnt++;
      if (reg_load_en)
        got_ld.push_back({reg_load_addr, reg_i_load_loc, reg_j_load_loc,
                          reg_m_load_size, reg_n_load_size, reg_load_element});
      if (mem_store_en) begin
        if (st_first < 0) st_first = cyc;
        st_last = cyc;
        got_st.push_back({mem_m_store_size, mem_n_store_size, mem_store_element});
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_mon();
    ack_cnt = 0; ack_first = -1; err_cnt = 0; st_first = -1; st_last = -1;
    got_ld.delete(); got_st.delete(); exp_ld.delete(); exp_st.delete();
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(load_ready && store_ready) && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("idle_wait_timeout", 64'(t < 50), 64'd1);
  endtask

  task automatic rand_data();
    for (int k = 0; k < 16; k++) ld_data[k] = $urandom;
  endtask

  // Presents a load request; the model records what the matrix should become.
  task automatic start_load(input logic [2:0] addr, input int m, input int n, input bit both);
    wait_idle();
    clear_mon();
    cur_valid = (m >= 1) && (m <= M) && (n >= 1) && (n <= N);
    cur_mn = cur_valid ? m * n : 0;
    for (int k = 0; k < cur_mn; k++) begin
      exp_ld.push_back({addr, 3'(k / n), 3'(k % n), 3'(m), 3'(n), ld_data[k]});
      mdl_data[addr][k / n][k % n] = ld_data[k];
    end
    if (cur_valid) begin
      mdl_m[addr] = m;
      mdl_n[addr] = n;
    end
    mem_load_addr   = addr;
    mem_m_load_size = 3'(m);
    mem_n_load_size = 3'(n);
    load_req        = 1'b1;
    if (both) begin
      store_req      = 1'b1;
      mem_store_addr = 3'd1;
    end
    acc_cyc = cyc;
  endtask

  task automatic run_load(input string tag);
    int k = 0;
    @(posedge clk); #1;
    load_req  = 1'b0;
    store_req = 1'b0;
    repeat (cur_mn + 5) begin
      if (mem_load_ack && k < 16) begin
        mem_load_element = ld_data[k];
        k++;
      end
      @(posedge clk); #1;
    end
    chk({tag, "_acks"}, 64'(ack_cnt), 64'(cur_mn));
    chk({tag, "_err"}, 64'(err_cnt), cur_valid ? 64'd0 : 64'd1);
    if (cur_valid) chk({tag, "_ack_lat"}, 64'(ack_first), 64'(acc_cyc + 1));
    chk({tag, "_nwr"}, 64'(got_ld.size()), 64'(exp_ld.size()));
    chk({tag, "_no_store"}, 64'(got_st.size()), 64'd0);
    for (int q = 0; q < exp_ld.size(); q++)
      chk({tag, "_wr"}, (q < got_ld.size()) ? 64'(got_ld[q]) : 64'hdead, 64'(exp_ld[q]));
  endtask

  task automatic do_store(input logic [2:0] addr, input string tag);
    int m, n, mn;
    bit valid;
    wait_idle();
    clear_mon();
    m = mdl_m[addr];
    n = mdl_n[addr];
    valid = (m >= 1) && (n >= 1);
    mn = valid ? m * n : 0;
    for (int k = 0; k < mn; k++)
      exp_st.push_back({3'(m), 3'(n), mdl_data[addr][k / n][k % n]});
    mem_store_addr = addr;
    store_req = 1'b1;
    acc_cyc = cyc;
    @(posedge clk); #1;
    store_req = 1'b0;
    repeat (mn + 6) begin
      @(posedge clk); #1;
    end
    chk({tag, "_nst"}, 64'(got_st.size()), 64'(mn));
    chk({tag, "_err"}, 64'(err_cnt), valid ? 64'd0 : 64'd1);
    chk({tag, "_no_ack"}, 64'(ack_cnt), 64'd0);
    if (valid) begin
      chk({tag, "_lat"}, 64'(st_first), 64'(acc_cyc + 2));
      chk({tag, "_contig"}, 64'(st_last - st_first), 64'(mn - 1));
    end
    for (int q = 0; q < exp_st.size(); q++)
      chk({tag, "_el"}, (q < got_st.size()) ? 64'(got_st[q]) : 64'hdead, 64'(exp_st[q]));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"}, 64'(mem_load_ack), 64'd0);
    chk({tag, "_err"}, 64'(mem_load_error), 64'd0);
    chk({tag, "_sten"}, 64'(mem_store_en), 64'd0);
    chk({tag, "_rlen"}, 64'(reg_load_en), 64'd0);
    chk({tag, "_rsen"}, 64'(reg_store_en), 64'd0);
    chk({tag, "_rlel"}, 64'(reg_load_element), 64'd0);
    chk({tag, "_rli"}, 64'({reg_i_load_loc, reg_j_load_loc}), 64'd0);
    chk({tag, "_lrdy"}, 64'(load_ready), 64'd1);
    chk({tag, "_srdy"}, 64'(store_ready), 64'd1);
    chk({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int a = 0; a < 8; a++) begin
      mdl_m[a] = 0;
      mdl_n[a] = 0;
    end
    clear_mon();
    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // directed 2x3 load of 1.0 .. 6.0 into register 1, then store it back
    ld_data[0] = 32'h3f800000; ld_data[1] = 32'h40000000; ld_data[2] = 32'h40400000;
    ld_data[3] = 32'h40800000; ld_data[4] = 32'h40a00000; ld_data[5] = 32'h40c00000;
    start_load(3'd1, 2, 3, 1'b0);
    run_load("ld2x3");
    do_store(3'd1, "st2x3");

    // zero-row load is rejected
    rand_data();
    start_load(3'd3, 0, 2, 1'b0);
    run_load("ld_m0");

    // simultaneous requests: load wins, store only after reissue
    rand_data();
    start_load(3'd4, 1, 4, 1'b1);
    run_load("ld_both");
    do_store(3'd1, "st_reissue");
    do_store(3'd4, "st_1x4");

    // store from a register never written
    do_store(3'd7, "st_empty");

    // reset in the middle of a 4x4 load
    rand_data();
    start_load(3'd2, 4, 4, 1'b0);
    @(posedge clk); #1;
    load_req = 1'b0;
    k = 0;
    while (k < 3) begin
      if (mem_load_ack) begin
        mem_load_element = ld_data[k];
        k++;
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    chk_zero("abort");
    rand_data();
    start_load(3'd2, 4, 4, 1'b0);
    @(negedge clk); rst = 1'b1;
    run_load("ld_after_rst");
    do_store(3'd2, "st_after_rst");

    // maximum-size matrix
    rand_data();
    start_load(3'd5, M, N, 1'b0);
    run_load("ld_max");
    do_store(3'd5, "st_max");

    // random loads and stores
    for (int r = 0; r < 10; r++) begin
      rand_data();
      start_load(3'($urandom_range(0, 5)), $urandom_range(0, 5), $urandom_range(0, 5), 1'b0);
      run_load("ld_rand");
      do_store(3'($urandom_range(0, 5)), "st_rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
